// File: rtl/shift_seq_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
// Shared definitions for the shift-enable sequencer: the controller state
// enum and the default configuration constants used as parameter defaults.
// Optional feature macro used elsewhere in this slice: SHIFT_SEQ_ABORT_EN.
// -----------------------------------------------------------------------------
package shift_seq_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SHIFT  = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int                     DEF_PATTERN_W   = 4;
  localparam logic [DEF_PATTERN_W-1:0] DEF_PATTERN   = 4'b1101;
  localparam int                     DEF_SHIFT_LEN   = 4;
  localparam int                     DEF_UNIT_CYCLES = 1000;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl_if
// Host/datapath-facing signals of the shift sequencer.
//   data      serial input bit, sampled every rising edge
//   ack       host acknowledge (meaningful only while done is high)
//   abort     cancel request (present only with SHIFT_SEQ_ABORT_EN)
//   shift_ena high during the SHIFT_LEN-cycle capture window
//   counting  high during the timed count phase
//   done      high until acknowledged
//   delay     captured delay field; remaining units while counting
// Modports: master = host side (drives data/ack/abort), slave = sequencer.
// -----------------------------------------------------------------------------
interface shift_seq_ctrl_if
  import shift_seq_pkg::*;
#(
  parameter int SHIFT_LEN = DEF_SHIFT_LEN
) ();

  logic                 data;
  logic                 ack;
`ifdef SHIFT_SEQ_ABORT_EN
  logic                 abort;
`endif
  logic                 shift_ena;
  logic                 counting;
  logic                 done;
  logic [SHIFT_LEN-1:0] delay;

`ifdef SHIFT_SEQ_ABORT_EN
  modport master (output data, ack, abort, input shift_ena, counting, done, delay);
  modport slave  (input data, ack, abort, output shift_ena, counting, done, delay);
`else
  modport master (output data, ack, input shift_ena, counting, done, delay);
  modport slave  (input data, ack, output shift_ena, counting, done, delay);
`endif

endinterface

// File: rtl/shift_seq_unit_timer.sv
// -----------------------------------------------------------------------------
// shift_seq_unit_timer
// Down-counter timing one delay unit of UNIT_CYCLES clocks.
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   i_load  load UNIT_CYCLES-1 (wins over i_en)
//   i_en    decrement by one (holds at zero)
//   o_zero  counter currently reads zero
// -----------------------------------------------------------------------------
module shift_seq_unit_timer
  import shift_seq_pkg::*;
#(
  parameter int UNIT_CYCLES = DEF_UNIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_zero
);

  localparam int            TW     = $clog2(UNIT_CYCLES);
  localparam logic [TW-1:0] RELOAD = TW'(UNIT_CYCLES - 1);

  logic [TW-1:0] r_cnt;

  // Unit down-counter: load on phase entry / unit reload, otherwise count down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= RELOAD;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - TW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
// Sequencer for the shift-enable datapath: hunts for PATTERN on the serial
// input, opens a SHIFT_LEN-cycle capture window for the delay field, counts
// (delay+1)*UNIT_CYCLES cycles, then holds done until acknowledged.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears all state
//   bus    shift_seq_ctrl_if.slave (data, ack, [abort], shift_ena,
//          counting, done, delay)
// Optional feature: define SHIFT_SEQ_ABORT_EN to add the abort input.
// Outputs are decoded from the state register or come straight from r_delay,
// so no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int                   PATTERN_W   = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN     = DEF_PATTERN,
  parameter int                   SHIFT_LEN   = DEF_SHIFT_LEN,
  parameter int                   UNIT_CYCLES = DEF_UNIT_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  shift_seq_ctrl_if.slave bus
);

  localparam int FW = $clog2(PATTERN_W + 1);
  localparam int CW = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;

  state_e               r_state;
  state_e               w_next_state;
  logic [PATTERN_W-1:0] r_hist;
  logic [PATTERN_W-1:0] w_hist_shift;
  logic [FW-1:0]        r_fill;
  logic [FW-1:0]        w_fill_inc;
  logic [CW-1:0]        r_cap_cnt;
  logic [SHIFT_LEN-1:0] r_delay;
  logic                 w_match;
  logic                 w_cap_last;
  logic                 w_timer_zero;
  logic                 w_timer_load;
  logic                 w_timer_en;
  logic                 w_abort;

  // The match looks at the history including the bit arriving this edge,
  // so SHIFT starts right after the last pattern bit is sampled.
  assign w_hist_shift = {r_hist[PATTERN_W-2:0], bus.data};
  assign w_fill_inc   = (r_fill == FW'(PATTERN_W)) ? r_fill : (r_fill + FW'(1));
  assign w_match      = (w_fill_inc >= FW'(PATTERN_W)) && (w_hist_shift == PATTERN);
  assign w_cap_last   = (r_cap_cnt == CW'(SHIFT_LEN - 1));

`ifdef SHIFT_SEQ_ABORT_EN
  assign w_abort = bus.abort && (r_state != SEARCH);
`else
  assign w_abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SEARCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and unit-timer control; abort outranks ack and completion.
  always_comb begin
    w_next_state = r_state;
    w_timer_load = 1'b0;
    w_timer_en   = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_match) begin
          w_next_state = SHIFT;
        end else begin
          w_next_state = SEARCH;
        end
      end
      SHIFT: begin
        w_timer_load = w_cap_last;
        if (w_abort) begin
          w_next_state = SEARCH;
        end else if (w_cap_last) begin
          w_next_state = COUNT;
        end else begin
          w_next_state = SHIFT;
        end
      end
      COUNT: begin
        w_timer_en   = 1'b1;
        w_timer_load = w_timer_zero && (r_delay != '0);
        if (w_abort) begin
          w_next_state = SEARCH;
        end else if (w_timer_zero && (r_delay == '0)) begin
          w_next_state = DONE;
        end else begin
          w_next_state = COUNT;
        end
      end
      DONE: begin
        if (w_abort || bus.ack) begin
          w_next_state = SEARCH;
        end else begin
          w_next_state = DONE;
        end
      end
      default: begin
        w_next_state = SEARCH;
      end
    endcase
  end

  // History/fill only advance while hunting; anywhere else (and on the
  // matching edge) they are held clear so stale bits never form a match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if ((r_state == SEARCH) && !w_match) begin
      r_hist <= w_hist_shift;
      r_fill <= w_fill_inc;
    end else begin
      r_hist <= '0;
      r_fill <= '0;
    end
  end

  // Capture-window position counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap_cnt <= '0;
    end else if ((r_state == SHIFT) && !w_cap_last) begin
      r_cap_cnt <= r_cap_cnt + CW'(1);
    end else begin
      r_cap_cnt <= '0;
    end
  end

  // Delay register: MSB-first capture, then one decrement per finished unit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_delay <= '0;
    end else if (w_abort) begin
      r_delay <= '0;
    end else if (r_state == SHIFT) begin
      r_delay <= {r_delay[SHIFT_LEN-2:0], bus.data};
    end else if ((r_state == COUNT) && w_timer_zero && (r_delay != '0)) begin
      r_delay <= r_delay - SHIFT_LEN'(1);
    end else begin
      r_delay <= r_delay;
    end
  end

  shift_seq_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (reset),
    .i_load (w_timer_load),
    .i_en   (w_timer_en),
    .o_zero (w_timer_zero)
  );

  assign bus.shift_ena = (r_state == SHIFT);
  assign bus.counting  = (r_state == COUNT);
  assign bus.done      = (r_state == DONE);
  assign bus.delay     = r_delay;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_ctrl
// Self-checking bench for shift_seq_ctrl with UNIT_CYCLES=10, PATTERN=1101,
// SHIFT_LEN=4. A phase/timeline reference model predicts every output each
// cycle; directed sequences add hand-computed expectations, followed by a
// randomized stream. Abort checks are built when SHIFT_SEQ_ABORT_EN is defined.
// -----------------------------------------------------------------------------
module tb_shift_seq_ctrl;

  localparam int         U   = 10;
  localparam int         PW  = 4;
  localparam int         SL  = 4;
  localparam logic [3:0] PAT = 4'b1101;

  localparam int P_SEARCH = 0;
  localparam int P_SHIFT  = 1;
  localparam int P_COUNT  = 2;
  localparam int P_DONE   = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  shift_seq_ctrl_if #(.SHIFT_LEN(SL)) bus ();

  shift_seq_ctrl #(
    .PATTERN_W   (PW),
    .PATTERN     (PAT),
    .SHIFT_LEN   (SL),
    .UNIT_CYCLES (U)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  int   m_phase   = P_SEARCH;
  bit   m_hist[$];
  int   m_caps    = 0;
  int   m_delay   = 0;
  int   m_start   = 0;
  int   m_elapsed = 0;
  logic m_d, m_a, m_ab;
  logic [PW-1:0] m_pat;

  // Inputs change at negedge+1, so at a negedge they still hold what the
  // preceding rising edge sampled: step the model, then compare.
  always @(negedge clk) begin
    if (reset) begin
      m_phase = P_SEARCH;
      m_hist.delete();
      m_delay = 0;
      m_caps  = 0;
    end else begin
      m_d  = bus.data;
      m_a  = bus.ack;
      m_ab = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
      m_ab = bus.abort;
`endif
      if (m_ab && (m_phase != P_SEARCH)) begin
        m_phase = P_SEARCH;
        m_delay = 0;
        m_hist.delete();
      end else begin
        case (m_phase)
          P_SEARCH: begin
            m_hist.push_back(m_d);
            if (m_hist.size() > PW) void'(m_hist.pop_front());
            if (m_hist.size() == PW) begin
              for (int i = 0; i < PW; i++) m_pat[PW-1-i] = m_hist[i];
              if (m_pat == PAT) begin
                m_phase = P_SHIFT;
                m_caps  = 0;
                m_hist.delete();
              end
            end
          end
          P_SHIFT: begin
            m_delay = ((m_delay << 1) | int'(m_d)) & ((1 << SL) - 1);
            m_caps++;
            if (m_caps == SL) begin
              m_phase   = P_COUNT;
              m_start   = m_delay;
              m_elapsed = 0;
            end
          end
          P_COUNT: begin
            m_elapsed++;
            if (m_elapsed == (m_start + 1) * U) begin
              m_phase = P_DONE;
              m_delay = 0;
            end else begin
              m_delay = m_start - (m_elapsed / U);
            end
          end
          default: begin
            if (m_a) m_phase = P_SEARCH;
          end
        endcase
      end
    end
    chk("m_shift_ena", int'(bus.shift_ena), int'(m_phase == P_SHIFT));
    chk("m_counting",  int'(bus.counting),  int'(m_phase == P_COUNT));
    chk("m_done",      int'(bus.done),      int'(m_phase == P_DONE));
    chk("m_delay",     int'(bus.delay),     m_delay);
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic d, input logic a);
    @(negedge clk);
    #1;
    bus.data = d;
    bus.ack  = a;
  endtask

  task automatic send_pat();
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
  endtask

  // Call right after the last delay bit was driven.
  task automatic measure(input int exp_d, input int exp_len);
    int n;
    @(negedge clk);
    #1;
    chk("cnt_start", int'(bus.counting), 1);
    chk("cnt_delay", int'(bus.delay), exp_d);
    n = 0;
    while ((bus.counting === 1'b1) && (n < 2000)) begin
      n++;
      if ((exp_len > U) && (n == U + 1)) chk("cnt_dec", int'(bus.delay), exp_d - 1);
      @(negedge clk);
      #1;
    end
    chk("cnt_len", n, exp_len);
    chk("done_rise", int'(bus.done), 1);
    chk("done_delay0", int'(bus.delay), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data = 1'b0;
    bus.ack  = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_shift_ena", int'(bus.shift_ena), 0);
    chk("rst_counting",  int'(bus.counting), 0);
    chk("rst_done",      int'(bus.done), 0);
    chk("rst_delay",     int'(bus.delay), 0);
    reset = 1'b0;

    // Basic run: delay 0010 -> 30 counting cycles.
    send_pat();
    send(1'b0, 1'b0);
    chk("basic_shift_on", int'(bus.shift_ena), 1);
    send(1'b0, 1'b1);   // ack in SHIFT is ignored
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    chk("basic_shift_4th", int'(bus.shift_ena), 1);
    measure(2, 30);
    // Bits in DONE plus the ack edge must not seed a match afterwards.
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    chk("done_hold", int'(bus.done), 1);
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    chk("done_fall", int'(bus.done), 0);
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 1'b0);
      chk("no_match_after_done", int'(bus.shift_ena), 0);
    end

    // Reset mid-count, then a full pattern is needed; delay 0000 -> 10.
    send_pat();
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_counting", int'(bus.counting), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_counting", int'(bus.counting), 0);
    chk("arst_delay",    int'(bus.delay), 0);
    chk("arst_done",     int'(bus.done), 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    bus.data = 1'b1;
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    chk("partial_no_shift", int'(bus.shift_ena), 0);
    send(1'b0, 1'b0);
    chk("full_pat_shift", int'(bus.shift_ena), 1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    measure(0, 10);
    send(1'b0, 1'b1);
    send(1'b0, 1'b0);
    chk("ack_done_fall", int'(bus.done), 0);

    // Overlap 1,1,1,0,1 ; delay 1111 with ack held high the whole time.
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    chk("ovl_not_yet", int'(bus.shift_ena), 0);
    send(1'b1, 1'b0);
    chk("ovl_match", int'(bus.shift_ena), 1);
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    measure(15, 160);
    send(1'b0, 1'b0);
    chk("ack_held_done_1cyc", int'(bus.done), 0);

    // Noise 1,1,0,0,1,1,0,1 -> one match on the last bit; delay 0001.
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    chk("noise_no_shift", int'(bus.shift_ena), 0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    chk("noise_match", int'(bus.shift_ena), 1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    measure(1, 20);
    send(1'b0, 1'b1);
    send(1'b0, 1'b0);

`ifdef SHIFT_SEQ_ABORT_EN
    // Abort in COUNT cycle 5.
    send_pat();
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    repeat (5) begin
      @(negedge clk);
      #1;
    end
    chk("abort_pre_counting", int'(bus.counting), 1);
    bus.abort = 1'b1;
    @(negedge clk);
    #1;
    bus.abort = 1'b0;
    chk("abort_counting", int'(bus.counting), 0);
    chk("abort_delay",    int'(bus.delay), 0);
    chk("abort_shift",    int'(bus.shift_ena), 0);
    // Abort together with ack in DONE.
    send_pat();
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    measure(0, 10);
    bus.abort = 1'b1;
    bus.ack   = 1'b1;
    @(negedge clk);
    #1;
    bus.abort = 1'b0;
    bus.ack   = 1'b0;
    chk("abort_ack_done", int'(bus.done), 0);
    chk("abort_ack_delay", int'(bus.delay), 0);
`endif

    // Randomized stream checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      bus.data = 1'($urandom_range(0, 1));
      bus.ack  = ($urandom_range(0, 3) == 0);
`ifdef SHIFT_SEQ_ABORT_EN
      bus.abort = ($urandom_range(0, 99) == 0);
`endif
    end
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencer for the 4-cycle shift-enable datapath. It watches a serial `data` stream for a start pattern, then asserts `shift_ena` for exactly SHIFT_LEN cycles to capture a delay field. It then runs a timed count phase of (delay+1)×UNIT_CYCLES cycles and holds `done` until the host acknowledges. It sits between the serial input pin and the shift register/timer datapath, and is the sole owner of `shift_ena`.

## Interface
- PATTERN_W, 4, start-pattern width
- PATTERN, 4'b1101, start pattern; first-received bit is the MSB
- SHIFT_LEN, 4, shift-window length and width of the delay field
- UNIT_CYCLES, 1000, clock cycles per delay unit; must be ≥2
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- data  in  1  serial input, sampled every rising edge
- ack  in  1  host acknowledge; only meaningful in DONE
- abort  in  1  exists only with SHIFT_SEQ_ABORT_EN
- shift_ena  out  1  high during the shift window
- counting  out  1  high during the count phase
- done  out  1  high until acknowledged
- delay  out  SHIFT_LEN  delay register; during COUNT, the number of remaining units

## Operation
- States are SEARCH, SHIFT, COUNT and DONE. Reset enters SEARCH.
- **SEARCH**
  - A history shift register and a fill counter are cleared on entry.
  - Each edge shifts `data` into the history.
  - A match requires the fill counter to be ≥PATTERN_W and history == PATTERN. Overlapping matches are legal, e.g. 1,1,1,0,1 matches on the fifth bit.
  - On a match, go to SHIFT.
- **SHIFT**
  - `shift_ena`=1.
  - Each edge does delay ← {delay[SHIFT_LEN-2:0], data}, so the MSB is captured first.
  - A 0..SHIFT_LEN-1 counter is used; after the SHIFT_LEN-th capture edge, go to COUNT.
- **COUNT**
  - `counting`=1.
  - The unit timer loads UNIT_CYCLES-1 on entry and decrements every edge.
  - When the timer reaches 0:
    - if delay==0, go to DONE;
    - otherwise delay decrements and the timer reloads.
- **DONE**
  - `done`=1.
  - `ack`=1 at an edge sends the block to SEARCH, with history and fill counter cleared. Bits seen in SHIFT, COUNT or DONE never contribute to a match.
- `ack` is ignored outside DONE.
- `delay` is not cleared in SEARCH. It reads 0 after a natural completion.
- All outputs are registered or decoded directly from state. There is no combinational path from any input to any output.

## Timing
- Reset values: `shift_ena`=0, `counting`=0, `done`=0, `delay`=0, state=SEARCH.
- Reset assertion in any state takes effect immediately, including mid-shift and mid-count.
- Last pattern bit sampled at edge t: `shift_ena` rises after t and stays high for exactly SHIFT_LEN cycles.
- Capture edges are t+1 through t+SHIFT_LEN.
- `counting` is high for exactly (delay+1)×UNIT_CYCLES cycles, starting the cycle after the last capture edge.
- `done` rises the cycle `counting` falls, with no gap.
- `ack` sampled at edge u: `done` falls after u. The earliest possible new match uses the bits sampled at edges u+1 through u+PATTERN_W.
- `ack` held high continuously from before DONE: DONE lasts exactly 1 cycle.
- `shift_ena`, `counting` and `done` are mutually exclusive (one-hot or all low).

## Configuration
- **SHIFT_SEQ_ABORT_EN defined**
  - The `abort` port exists.
  - `abort`=1 at an edge in SHIFT, COUNT or DONE sends the block to SEARCH next cycle, clears `delay` to 0, and drops all outputs.
  - `abort` has priority over `ack` and over completion. It is ignored in SEARCH.
- **Not defined**
  - There is no `abort` port and no abort logic. Everything else is identical.

## Structure
- Package `shift_seq_pkg` holds:
  - the state enum (SEARCH, SHIFT, COUNT, DONE);
  - default constants PATTERN_W, PATTERN, SHIFT_LEN and UNIT_CYCLES.
- Sub-module `shift_seq_unit_timer`:
  - the UNIT_CYCLES down-counter, with width $clog2(UNIT_CYCLES);
  - inputs `load` and `en`; output `zero`;
  - asynchronous active-high reset.
- The FSM, history register and delay register stay in the top module.

## Test plan
The bench uses UNIT_CYCLES=10, PATTERN=1101 and SHIFT_LEN=4.
- **Reset mid-count:** assert reset during COUNT → all outputs 0 immediately (asynchronous); after release, a full pattern is required before `shift_ena`.
- **Basic run:** data 1,1,0,1 then 0,0,1,0 → `shift_ena` high 4 cycles, `delay`=2, `counting` high 30 cycles, then `done`=1 until `ack`.
- **Overlap and noise:**
  - data 1,1,1,0,1 → match on the fifth bit;
  - data 1,1,0,0,1,1,0,1 → a single match on the last bit.
- **Delay extremes:**
  - delay 0000 → `counting` 10 cycles;
  - delay 1111 → 160 cycles, with `delay` decrementing 15→0 every 10 cycles.
- **Ack handling:** `ack` pulses during SHIFT/COUNT are ignored; `ack` held high → `done` 1 cycle; pattern bits sent during DONE do not trigger a match.
- **Abort (SHIFT_SEQ_ABORT_EN):** `abort` at COUNT cycle 5 → SEARCH next cycle, `delay`=0, `counting`=0; `abort` and `ack` together in DONE → SEARCH, with abort behaviour.
